// File: rtl/key_matrix_scan_if.sv
// Key event handshake bundle between the keypad scanner (master) and its consumer (slave).
interface key_matrix_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       key_ovf;

  modport master (output key_code, key_valid, key_down, key_ovf, input key_ack);
  modport slave  (input key_code, key_valid, key_down, key_ovf, output key_ack);
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner: column strobe, frame debounce, valid/ack press events.
// Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module key_matrix_scan #(
  parameter int unsigned F_CLK                = 50000000,
  parameter int unsigned F_SCAN               = 1000,
  parameter int unsigned DEBOUNCE_FRAMES      = 5,
  parameter int unsigned REPEAT_DELAY_FRAMES  = 125,
  parameter int unsigned REPEAT_PERIOD_FRAMES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  key_matrix_scan_if.master key_if
);

  localparam int unsigned DIV     = F_CLK / F_SCAN;
  localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_MAX = (DEBOUNCE_FRAMES > REPEAT_DELAY_FRAMES) ?
                                    DEBOUNCE_FRAMES : REPEAT_DELAY_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (DIV < 2 || DEBOUNCE_FRAMES == 0 || REPEAT_DELAY_FRAMES == 0 || REPEAT_PERIOD_FRAMES == 0)
  begin : g_cfg_chk
    $error("key_matrix_scan: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_DEB_PRESS, S_HELD, S_DEB_REL} state_t;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_c;
  logic [1:0]    col_q, col_nxt_c;
  logic [3:0]    col_out_q;
  logic [15:0]   frame_q, frame_d;
  logic          eval_q;
  logic [4:0]    ones_c;
  logic [3:0]    c_code_c;
  logic          c_key_c;
  state_t        state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q, cnt_inc_c;
  logic          deb_done_c;
  logic          key_down_q;
  logic          press_evt_c;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_ovf_q;

  // Row synchronizer; idle rows read as released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  assign tick_c    = (tick_cnt_q == TW'(DIV - 1));
  assign col_nxt_c = col_q + 2'd1;

  // Frame map bit index is row*4+col, so a single set bit is directly the key code
  always_comb begin
    frame_d = frame_q;
    for (int r = 0; r < 4; r++) frame_d[{2'(r), col_q}] = ~row_sync_q[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      col_q      <= 2'd0;
      col_out_q  <= 4'b1110;
      frame_q    <= '0;
      eval_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TW'(1);
      eval_q     <= tick_c && (col_q == 2'd3);
      if (tick_c) begin
        frame_q   <= frame_d;
        col_q     <= col_nxt_c;
        col_out_q <= ~(4'b0001 << col_nxt_c);
      end
    end
  end

  // Frame candidate: valid only when exactly one key is seen
  always_comb begin
    ones_c   = '0;
    c_code_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        ones_c   = ones_c + 5'd1;
        c_code_c = 4'(i);
      end
    end
  end
  assign c_key_c = (ones_c == 5'd1);

  assign cnt_inc_c  = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
  assign deb_done_c = (cnt_inc_c >= CW'(DEBOUNCE_FRAMES));

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                                    REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_inc_c;
  logic          rpt_first_q, rpt_hit_c;

  assign rpt_inc_c = rpt_cnt_q + RW'(1);
  assign rpt_hit_c = (rpt_inc_c == (rpt_first_q ? RW'(REPEAT_DELAY_FRAMES) : RW'(REPEAT_PERIOD_FRAMES)));

  // Restarts on entry from debounce; frozen while in release debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (eval_q) begin
      if (state_q == S_DEB_PRESS) begin
        rpt_cnt_q   <= '0;
        rpt_first_q <= 1'b1;
      end else if (state_q == S_HELD && c_key_c) begin
        if (rpt_hit_c) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b0;
        end else begin
          rpt_cnt_q <= rpt_inc_c;
        end
      end
    end
  end
`endif

  always_comb begin
    press_evt_c = 1'b0;
    if (eval_q) begin
      case (state_q)
        S_DEB_PRESS: press_evt_c = c_key_c && (c_code_c == cand_q) && deb_done_c;
`ifdef KEY_REPEAT_EN
        S_HELD:      press_evt_c = c_key_c && rpt_hit_c;
`endif
        default:     press_evt_c = 1'b0;
      endcase
    end
  end

  // Debounce FSM, advanced once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      key_down_q <= 1'b0;
    end else if (eval_q) begin
      case (state_q)
        S_IDLE: begin
          if (c_key_c) begin
            cand_q  <= c_code_c;
            cnt_q   <= CW'(1);
            state_q <= S_DEB_PRESS;
          end
        end
        S_DEB_PRESS: begin
          if (c_key_c && (c_code_c == cand_q)) begin
            cnt_q <= cnt_inc_c;
            if (deb_done_c) begin
              state_q    <= S_HELD;
              key_down_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HELD: begin
          if (!c_key_c) begin
            cnt_q   <= CW'(1);
            state_q <= S_DEB_REL;
          end
        end
        S_DEB_REL: begin
          if (!c_key_c) begin
            cnt_q <= cnt_inc_c;
            if (deb_done_c) begin
              state_q    <= S_IDLE;
              key_down_q <= 1'b0;
            end
          end else begin
            state_q <= S_HELD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Event register; an ack in the same cycle frees the slot for a new event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_ovf_q   <= 1'b0;
    end else if (press_evt_c) begin
      if (!key_valid_q || key_if.key_ack) begin
        key_code_q  <= cand_q;
        key_valid_q <= 1'b1;
        key_ovf_q   <= 1'b0;
      end else begin
        key_ovf_q <= 1'b1;
      end
    end else if (key_valid_q && key_if.key_ack) begin
      key_valid_q <= 1'b0;
      key_ovf_q   <= 1'b0;
    end
  end

  assign col_out          = col_out_q;
  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_down  = key_down_q;
  assign key_if.key_ovf   = key_ovf_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboard bench for key_matrix_scan with a resistive-free 4x4 keypad model.
module tb_key_matrix_scan;

  localparam int FRAME = 32;  // DIV=8 cycles per column, 4 columns
  localparam int LAT   = 95;  // press at frame phase 2 -> valid at phase 1, three frames later

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          auto_ack = 1'b1;
  int          ack_req_cnt = 0;

  typedef struct { int code; int due; } exp_t;
  exp_t exp_q[$];

  key_matrix_scan_if kif ();

  key_matrix_scan #(
    .F_CLK(800), .F_SCAN(100), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_PERIOD_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .key_if(kif.master)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_phase(input int ph);
    do @(negedge clk); while ((cyc % FRAME) != ph);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic expect_ev(input int code, input int due);
    exp_t e;
    e.code = code;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each newly presented event and acks it
  initial begin : monitor
    bit seen = 1'b0;
    bit ack_pend = 1'b0;
    int ack_done_cnt = 0;
    exp_t e;
    kif.key_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        ack_pend = 1'b0;
        kif.key_ack = 1'b0;
      end else begin
        if (ack_pend) begin
          ack_pend = 1'b0;
          kif.key_ack = 1'b0;
          seen = 1'b0;
          chk("valid_after_ack", int'(kif.key_valid), 0);
        end
        if (kif.key_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_event_code", int'(kif.key_code), -1);
          end else begin
            e = exp_q.pop_front();
            chk("ev_code", int'(kif.key_code), e.code);
            chk("ev_down", int'(kif.key_down), 1);
            chk("ev_cycle", cyc, e.due);
          end
        end
        if (seen && kif.key_valid && !ack_pend && (auto_ack || ack_req_cnt != ack_done_cnt)) begin
          if (!auto_ack) ack_done_cnt++;
          kif.key_ack = 1'b1;
          ack_pend = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pc;
    repeat (3) @(negedge clk);
    chk("rst_col_out", int'(col_out), 14);
    chk("rst_code", int'(kif.key_code), 0);
    chk("rst_valid", int'(kif.key_valid), 0);
    chk("rst_down", int'(kif.key_down), 0);
    chk("rst_ovf", int'(kif.key_ovf), 0);
    rst = 1'b0;

    // Clean press of key 9 (row 2, col 1)
    wait_phase(2);
    keys[9] = 1'b1; pc = cyc;
    expect_ev(9, pc + LAT);
    wait_frames(5);
    keys[9] = 1'b0;
    wait_frames(5);
    chk("t1_down_released", int'(kif.key_down), 0);

    // Key 5 bouncing every 2 frames, then held
    wait_phase(2);
    keys[5] = 1'b1;
    wait_frames(2);
    keys[5] = 1'b0;
    wait_frames(2);
    keys[5] = 1'b1; pc = cyc;
    expect_ev(5, pc + LAT);
    wait_frames(5);
    keys[5] = 1'b0;
    wait_frames(5);

    // Keys 0 and 15 together are rejected; releasing 15 leaves key 0
    wait_phase(2);
    keys[0] = 1'b1; keys[15] = 1'b1;
    wait_frames(6);
    chk("multi_down", int'(kif.key_down), 0);
    chk("multi_valid", int'(kif.key_valid), 0);
    keys[15] = 1'b0; pc = cyc;
    expect_ev(0, pc + LAT);
    wait_frames(5);
    keys[0] = 1'b0;
    wait_frames(5);

    // Two presses without ack: second is dropped and flagged
    auto_ack = 1'b0;
    wait_phase(2);
    keys[3] = 1'b1; pc = cyc;
    expect_ev(3, pc + LAT);
    wait_frames(5);
    keys[3] = 1'b0;
    wait_frames(5);
    keys[7] = 1'b1;
    wait_frames(5);
    chk("ovf_code", int'(kif.key_code), 3);
    chk("ovf_valid", int'(kif.key_valid), 1);
    chk("ovf_flag", int'(kif.key_ovf), 1);
    chk("ovf_down", int'(kif.key_down), 1);
    ack_req_cnt++;
    repeat (4) @(negedge clk);
    chk("ovf_valid_cleared", int'(kif.key_valid), 0);
    chk("ovf_flag_cleared", int'(kif.key_ovf), 0);
    keys[7] = 1'b0;
    wait_frames(5);

    // Reset while a press is debouncing and an event is pending
    wait_phase(2);
    keys[6] = 1'b1; pc = cyc;
    expect_ev(6, pc + LAT);
    wait_frames(5);
    keys[6] = 1'b0;
    wait_frames(5);
    keys[2] = 1'b1;
    wait_frames(1);
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", int'(kif.key_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_col_out", int'(col_out), 14);
    chk("mid_rst_code", int'(kif.key_code), 0);
    chk("mid_rst_valid", int'(kif.key_valid), 0);
    chk("mid_rst_down", int'(kif.key_down), 0);
    chk("mid_rst_ovf", int'(kif.key_ovf), 0);
    keys[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    auto_ack = 1'b1;
    wait_phase(2);
    keys[2] = 1'b1; pc = cyc;
    expect_ev(2, pc + LAT);
    wait_frames(5);
    keys[2] = 1'b0;
    wait_frames(5);

`ifdef KEY_REPEAT_EN
    // Hold key 10: press event, repeat after 4 frames, then every 2
    wait_phase(2);
    keys[10] = 1'b1; pc = cyc;
    expect_ev(10, pc + LAT);
    expect_ev(10, pc + LAT + 4 * FRAME);
    expect_ev(10, pc + LAT + 6 * FRAME);
    expect_ev(10, pc + LAT + 8 * FRAME);
    wait_frames(11);
    chk("rpt_down_held", int'(kif.key_down), 1);
    keys[10] = 1'b0;
    wait_frames(4);
    chk("rpt_down_released", int'(kif.key_down), 0);
`endif

    wait_frames(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_matrix_scan.md
# key_matrix_scan

Scanning receiver for a 4x4 active-low matrix keypad. It is the input-side counterpart of the board's multiplexed 7-segment display scanner. It drives one keypad column low at a time at a fixed scan rate and samples the row lines. It debounces whole scan frames, and presents each new key press as a 4-bit code through a valid/ack handshake to downstream logic such as display control or counters.

## Interface
- `F_CLK`, default 50000000: system clock frequency in Hz.
- `F_SCAN`, default 1000: column-advance rate in Hz. `DIV = F_CLK/F_SCAN` must be ≥ 2.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical frames (frame = 4 columns) needed to accept a press or a release.
- `REPEAT_DELAY_FRAMES`, default 125: frames held before the first auto-repeat. Used only with `KEY_REPEAT_EN`.
- `REPEAT_PERIOD_FRAMES`, default 25: frames between auto-repeats. Used only with `KEY_REPEAT_EN`.
- `clk  in  1`: system clock. All logic is in this single domain.
- `rst  in  1`: reset, asynchronous, active-high.
- `row_in  in  [3:0]`: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out  out  [3:0]`: column drive, one-cold. Low means the column is selected.
- `key_code  out  [3:0]`: pressed key, `row*4 + col`. Stable while `key_valid` is high.
- `key_valid  out  1`: a press event is pending. Held high until acknowledged.
- `key_ack  in  1`: consumer acknowledge, sampled on `clk`.
- `key_down  out  1`: level, high while a debounced key is held.
- `key_ovf  out  1`: sticky flag, set when a press event is lost.

## Operation
- `row_in` passes through a 2-FF synchronizer before any use.
- Tick generator: counter runs 0..DIV-1. `tick` is high for one cycle when the counter equals DIV-1. The design uses a clock enable only and generates no derived clocks.
- On each `tick`:
  - Latch the inverted synchronized rows for the current column into the column's slot of a 16-bit frame map.
  - Advance the column 0→1→2→3→0.
- Frame end is the tick that samples column 3. One cycle later the frame is evaluated to a candidate C:
  - C is none if 0 bits are set.
  - C is key k if exactly 1 bit is set.
  - C is none if ≥2 bits are set. Ghosting and multi-key frames are rejected.
- The FSM evaluates only at frame evaluation. Counter `cnt` counts frames.
  - IDLE:
    - C=k: latch k as `cand`, set `cnt=1`, go to DEB_PRESS.
  - DEB_PRESS:
    - C==`cand`: increment `cnt`. When `cnt` reaches DEBOUNCE_FRAMES, go to HELD, set `key_down=1`, and raise a press event with code `cand`.
    - Any other C: go to IDLE.
  - HELD:
    - C=none: set `cnt=1`, go to DEB_REL.
    - C is any key, same or different: stay in HELD with no event.
  - DEB_REL:
    - C=none: increment `cnt`. When `cnt` reaches DEBOUNCE_FRAMES, go to IDLE and set `key_down=0`.
    - C≠none: return to HELD with no new event.
- Handshake:
  - A press event while `key_valid=0` loads `key_code` and sets `key_valid=1`.
  - `key_ack=1` while `key_valid=1` clears `key_valid` and `key_ovf` on that edge.
  - `key_ack` while `key_valid=0` is ignored.
  - A press event while `key_valid=1` and `key_ack=0` is dropped: `key_code` is unchanged and `key_ovf` is set to 1.
  - A press event and `key_ack` in the same cycle: the new event is loaded, `key_valid` stays 1, and `key_ovf` is cleared.
- Width rule: `cnt` is sized for max(DEBOUNCE_FRAMES, REPEAT_DELAY_FRAMES) and saturates, never wrapping.

## Timing
- Reset values: `col_out=4'b1110`, `key_code=0`, `key_valid=0`, `key_down=0`, `key_ovf=0`. FSM in IDLE. Tick counter, column index, frame map and `cnt` all 0.
- `col_out` changes on the edge after `tick`. Each column is driven for DIV cycles before it is sampled.
- `key_valid` rises and `key_down` changes 2 `clk` cycles after the frame-end tick of the qualifying frame: one cycle to evaluate, one cycle to register.
- Press latency from a clean contact, in frames: DEBOUNCE_FRAMES plus up to 1 partial frame plus 2 synchronizer cycles.
- `rst` asserted mid-operation clears everything immediately. A pending event is lost and no `key_ovf` is set.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In HELD, a frame counter restarts on entry.
  - After REPEAT_DELAY_FRAMES, and then every REPEAT_PERIOD_FRAMES, a press event with the held code is raised.
  - Repeat events follow the same handshake and overflow rules as normal press events.
  - DEB_REL pauses the repeat counter. Returning to HELD from DEB_REL resumes it without a restart.
- `KEY_REPEAT_EN` undefined: exactly one event per press. The repeat parameters are unused and the repeat logic is absent.

## Test plan
All scenarios use F_CLK=800, F_SCAN=100 (DIV=8), DEBOUNCE_FRAMES=3, and a keypad model.

- Hold row 2 × column 1 clean:
  - Required: `key_valid` rises with `key_code=9` and `key_down=1`, exactly 2 cycles after the 3rd qualifying frame-end tick.
  - Then pulse `key_ack`: `key_valid` falls on the next edge.
- Key 5 bouncing:
  - Stimulus: toggle row line every 2 frames for 6 frames, then hold.
  - Required: no event during bounce; a single event with `key_code=5` after 3 stable frames.
- Keys 0 and 15 held together:
  - Required: `key_valid` never rises and `key_down` stays 0.
  - Release key 15: an event with `key_code=0` follows.
- Two presses (3, then 7) without ack:
  - Required: `key_code` stays 3 and `key_ovf=1`.
  - `key_ack`: both `key_valid` and `key_ovf` go to 0.
- Assert `rst` while in DEB_PRESS with `key_valid=1`:
  - Required: all outputs at reset values on the next sample and `col_out=4'b1110`.
  - Re-press after reset: normal detection.
- With `KEY_REPEAT_EN`, REPEAT_DELAY_FRAMES=4, REPEAT_PERIOD_FRAMES=2, hold key 10 with the bench acking each event:
  - Required: events at the press, at +4 frames, then every 2 frames.
  - Release: `key_down=0` after 3 none-frames and no further events.
